// File: rtl/rename_free_list.sv
// Circular free list of physical register tags for the rename stage: multi-port allocate from
// the head, multi-port reclaim at the tail, head checkpoint/restore for branch recovery.
module rename_free_list #(
  parameter int unsigned ARCH_COUNT      = 32,
  parameter int unsigned VIRT_COUNT      = 256,
  parameter int unsigned VIRT_ADDR_WIDTH = $clog2(VIRT_COUNT),
  parameter int unsigned ALLOC_PORTS     = 4,
  parameter int unsigned FREE_PORTS      = 4,
  parameter int unsigned MAX_FREE        = VIRT_COUNT - ARCH_COUNT
) (
  input  logic                                           clk,
  input  logic                                           sync_rst,
  input  logic                                           clk_en,
  input  logic [ALLOC_PORTS-1:0]                         alloc_req,
  output logic                                           alloc_gnt,
  output logic [ALLOC_PORTS-1:0][VIRT_ADDR_WIDTH-1:0]    alloc_tag,
  input  logic [FREE_PORTS-1:0]                          free_en,
  input  logic [FREE_PORTS-1:0][VIRT_ADDR_WIDTH-1:0]     free_tag,
  input  logic                                           restore_en,
  input  logic [VIRT_ADDR_WIDTH-1:0]                     restore_head,
  output logic [VIRT_ADDR_WIDTH-1:0]                     head_ptr,
  output logic [VIRT_ADDR_WIDTH:0]                       free_count,
  output logic                                           overflow_err,
  output logic                                           underflow_err
);

  typedef logic [VIRT_ADDR_WIDTH-1:0] ptr_t;
  typedef logic [VIRT_ADDR_WIDTH:0]   cnt_t;
  typedef logic [VIRT_ADDR_WIDTH+1:0] ext_t;

  localparam cnt_t MaxFreeCnt = cnt_t'(MAX_FREE);
  localparam ext_t MaxFreeExt = ext_t'(MAX_FREE);

  ptr_t mem_q [VIRT_COUNT];
  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  cnt_t n_req, n_free, granted;
  ext_t free_sum;
  logic free_drop;
  logic free_we;
  ptr_t [FREE_PORTS-1:0] free_idx;

  // Requesting ports take consecutive entries from the head in port order.
  always_comb begin
    n_req = '0;
    for (int unsigned i = 0; i < ALLOC_PORTS; i++) begin
      alloc_tag[i] = mem_q[head_q + ptr_t'(n_req)];
      if (alloc_req[i]) n_req = n_req + cnt_t'(1);
    end
  end

  always_comb begin
    n_free = '0;
    for (int unsigned j = 0; j < FREE_PORTS; j++) begin
      free_idx[j] = tail_q + ptr_t'(n_free);
      if (free_en[j]) n_free = n_free + cnt_t'(1);
    end
  end

  assign alloc_gnt = clk_en & ~restore_en & ~sync_rst & (n_req != '0) & (n_req <= count_q);
  assign granted   = alloc_gnt ? n_req : '0;

  // Frees are not bypassed: the check uses the pre-edge count, and a batch that would
  // overfill the list is dropped whole while the allocation still proceeds.
  assign free_sum  = ext_t'(count_q) + ext_t'(n_free) - ext_t'(granted);
  assign free_drop = free_sum > MaxFreeExt;
  assign free_we   = ~free_drop;

  always_comb begin
    tail_d  = free_we ? tail_q + ptr_t'(n_free) : tail_q;
    head_d  = head_q + ptr_t'(granted);
    count_d = free_drop ? count_q - granted : cnt_t'(free_sum);
    ovf_d   = ovf_q | free_drop;
    unf_d   = unf_q;
    if (restore_en) begin
      head_d  = restore_head;
      count_d = cnt_t'(ptr_t'(tail_d - restore_head));
      unf_d   = unf_q | (cnt_t'(ptr_t'(tail_d - restore_head)) > MaxFreeCnt);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      for (int unsigned i = 0; i < VIRT_COUNT; i++) begin
        mem_q[i] <= (i < MAX_FREE) ? ptr_t'(ARCH_COUNT + i) : '0;
      end
      head_q  <= '0;
      tail_q  <= ptr_t'(MAX_FREE);
      count_q <= MaxFreeCnt;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (clk_en) begin
      if (free_we) begin
        for (int unsigned j = 0; j < FREE_PORTS; j++) begin
          if (free_en[j]) mem_q[free_idx[j]] <= free_tag[j];
        end
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign head_ptr      = head_q;
  assign free_count    = count_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_rename_free_list.sv
// Scoreboarded bench for rename_free_list: a queue/array reference model predicts each cycle's
// outputs, and a negedge monitor compares them against the DUT.
module tb_rename_free_list;

  localparam int AC = 32;
  localparam int VC = 256;
  localparam int MF = VC - AC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             sync_rst, clk_en, alloc_gnt, restore_en, overflow_err, underflow_err;
  logic [3:0]       alloc_req, free_en;
  logic [3:0][7:0]  alloc_tag, free_tag;
  logic [7:0]       restore_head, head_ptr;
  logic [8:0]       free_count;

  rename_free_list dut (
    .clk           (clk),
    .sync_rst      (sync_rst),
    .clk_en        (clk_en),
    .alloc_req     (alloc_req),
    .alloc_gnt     (alloc_gnt),
    .alloc_tag     (alloc_tag),
    .free_en       (free_en),
    .free_tag      (free_tag),
    .restore_en    (restore_en),
    .restore_head  (restore_head),
    .head_ptr      (head_ptr),
    .free_count    (free_count),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  typedef struct packed {
    logic [3:0]      req;
    logic            gnt;
    logic [3:0][7:0] tags;
    logic [7:0]      head;
    logic [8:0]      cnt;
    logic            ovf;
    logic            unf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: list contents in an array indexed by unbounded-mod positions.
  logic [7:0] m_mem [VC];
  int         m_head, m_tail, m_cnt;
  bit         m_ovf, m_unf;
  int         held[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("alloc_gnt", 32'(alloc_gnt), 32'(e.gnt));
      check("head_ptr", 32'(head_ptr), 32'(e.head));
      check("free_count", 32'(free_count), 32'(e.cnt));
      check("overflow_err", 32'(overflow_err), 32'(e.ovf));
      check("underflow_err", 32'(underflow_err), 32'(e.unf));
      if (e.gnt) begin
        for (int i = 0; i < 4; i++) begin
          if (e.req[i]) check($sformatf("alloc_tag[%0d]", i), 32'(alloc_tag[i]), 32'(e.tags[i]));
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < VC; i++) m_mem[i] = (i < MF) ? 8'(AC + i) : 8'd0;
    m_head = 0;
    m_tail = MF;
    m_cnt  = MF;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    held.delete();
  endtask

  task automatic drive(input bit rst, input bit en, input logic [3:0] req, input logic [3:0] fen,
                       input logic [3:0][7:0] ft, input bit ren, input logic [7:0] rh);
    exp_t e;
    int   nr, nf, k, granted;
    sync_rst = rst; clk_en = en; alloc_req = req; free_en = fen; free_tag = ft;
    restore_en = ren; restore_head = rh;
    nr = $countones(req);
    e.req = req;
    e.gnt = en && !ren && !rst && nr > 0 && nr <= m_cnt;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      e.tags[i] = 8'd0;
      if (req[i]) begin
        e.tags[i] = m_mem[(m_head + k) % VC];
        k++;
      end
    end
    e.head = 8'(m_head);
    e.cnt  = 9'(m_cnt);
    e.ovf  = m_ovf;
    e.unf  = m_unf;
    exp_q.push_back(e);
    if (rst) begin
      model_reset();
    end else if (en) begin
      granted = e.gnt ? nr : 0;
      if (e.gnt) for (int i = 0; i < 4; i++) if (req[i]) held.push_back(int'(e.tags[i]));
      nf = $countones(fen);
      if (m_cnt + nf - granted > MF) begin
        m_ovf = 1'b1;
        nf = 0;
      end else begin
        k = 0;
        for (int j = 0; j < 4; j++) if (fen[j]) begin
          m_mem[(m_tail + k) % VC] = ft[j];
          k++;
        end
      end
      m_tail = (m_tail + nf) % VC;
      if (ren) begin
        m_head = int'(rh);
        m_cnt  = (m_tail - m_head + VC) % VC;
        if (m_cnt > MF) m_unf = 1'b1;
      end else begin
        m_head = (m_head + granted) % VC;
        m_cnt  = m_cnt + nf - granted;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit en, input logic [3:0] req, input logic [3:0] fen,
                      input bit ren, input logic [7:0] rh);
    logic [3:0][7:0] ft;
    for (int j = 0; j < 4; j++) begin
      if (fen[j] && held.size() > 0) ft[j] = 8'(held.pop_front());
      else ft[j] = 8'($urandom);
    end
    drive(1'b0, en, req, fen, ft, ren, rh);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 4'hf, 4'hf, 32'($urandom), 1'b1, 8'd7);
  endtask

  task automatic alloc_n(input int cycles, input logic [3:0] req);
    for (int c = 0; c < cycles; c++) step(1'b1, req, 4'h0, 1'b0, 8'd0);
  endtask

  initial begin
    logic [7:0] ckpt;
    sync_rst = 1'b1; clk_en = 1'b0; alloc_req = '0; free_en = '0; free_tag = '0;
    restore_en = 1'b0; restore_head = '0;
    @(posedge clk);
    #1;
    model_reset();

    // Wide and sparse allocation from reset.
    step(1'b1, 4'b1111, 4'h0, 1'b0, 8'd0);
    step(1'b1, 4'b0000, 4'h0, 1'b0, 8'd0);
    do_reset();
    step(1'b1, 4'b1010, 4'h0, 1'b0, 8'd0);
    step(1'b1, 4'b0000, 4'h0, 1'b0, 8'd0);

    // Drain to 2, then over-ask with and without a concurrent free.
    do_reset();
    alloc_n(55, 4'b1111);
    step(1'b1, 4'b0011, 4'h0, 1'b0, 8'd0);
    step(1'b1, 4'b0111, 4'h0, 1'b0, 8'd0);
    step(1'b1, 4'b0111, 4'b0001, 1'b0, 8'd0);
    step(1'b1, 4'b0000, 4'h0, 1'b0, 8'd0);

    // Full drain, full refill in freed order, reallocation across the pointer wrap.
    do_reset();
    alloc_n(56, 4'b1111);
    step(1'b1, 4'b0001, 4'h0, 1'b0, 8'd0);
    for (int c = 0; c < 56; c++) step(1'b1, 4'b0000, 4'b1111, 1'b0, 8'd0);
    alloc_n(56, 4'b1111);
    step(1'b1, 4'b0000, 4'h0, 1'b0, 8'd0);

    // Overflow at full occupancy stays sticky.
    do_reset();
    step(1'b1, 4'b0000, 4'b0001, 1'b0, 8'd0);
    for (int c = 0; c < 3; c++) step(1'b1, 4'b0000, 4'h0, 1'b0, 8'd0);

    // Restore past freed entries raises underflow.
    do_reset();
    alloc_n(2, 4'b1111);
    step(1'b1, 4'b0000, 4'b0011, 1'b0, 8'd0);
    step(1'b1, 4'b1111, 4'h0, 1'b1, 8'd0);
    step(1'b1, 4'b0000, 4'h0, 1'b0, 8'd0);

    // Clean restore returns the original tags; clk_en low freezes everything.
    do_reset();
    alloc_n(2, 4'b1111);
    step(1'b1, 4'b1111, 4'h0, 1'b1, 8'd0);
    step(1'b1, 4'b0001, 4'h0, 1'b0, 8'd0);
    step(1'b0, 4'b1111, 4'b1111, 1'b1, 8'd40);
    step(1'b0, 4'b0110, 4'b0011, 1'b0, 8'd0);
    step(1'b1, 4'b0000, 4'h0, 1'b0, 8'd0);

    // Random traffic with periodic resets and checkpoint restores.
    ckpt = 8'd0;
    for (int c = 0; c < 1500; c++) begin
      if (c % 300 == 0) begin
        do_reset();
        ckpt = 8'd0;
      end else begin
        if (c % 17 == 0) ckpt = 8'(m_head);
        step(($urandom % 8) != 0, 4'($urandom), 4'($urandom) & 4'($urandom),
             ($urandom % 20) == 0, ckpt);
      end
    end

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
